dma_rd_q_wr_arb: RTL and testbench
==================================

# dma_rd_q_wr_arb

Two-port arbiter that serializes DMA-read-queue write requests from the command processing unit (port 0) and the BAR0 register block (port 1) into the single write port of the DMA read queue FIFO. Simultaneous requests are no longer dropped. Each requester holds its entry until it receives a one-cycle acknowledge. The block sits between the two requesters and the queue inside the request manager, and applies round-robin fairness and FIFO-full backpressure.

## Interface
- DATA_W, 64, width of one DMA read queue entry
- clk  in  1  system clock; all logic on rising edge
- srst  in  1  synchronous reset, active-high
- en  in  1  block enable; when low, behaves as srst
- req0_wr_en_i  in  1  port 0 (CPM) request; held high until ack
- req0_wr_data_i  in  DATA_W  port 0 entry; stable while req0_wr_en_i high
- req0_wr_ack_o  out  1  port 0 acknowledge, one-cycle pulse
- req1_wr_en_i, req1_wr_data_i, req1_wr_ack_o: same as port 0, for BAR0
- q_full_i  in  1  DMA read queue full
- q_almost_full_i  in  1  DMA read queue has exactly one free slot
- q_wr_en_o  out  1  queue write strobe (registered)
- q_wr_data_o  out  DATA_W  queue write data (registered)
- busy_o  out  1  request pending or write in flight
- grant_cnt0_o, grant_cnt1_o  out  32  grants per port (see Configuration)
- stall_cnt_o  out  16  backpressure stall cycles (see Configuration)

## Operation
- Reset (srst or !en): q_wr_en_o=0, q_wr_data_o=0, req0/1_wr_ack_o=0, busy_o=0, last_grant=1 (port 0 wins first tie), all counters 0.
- Eligibility: port k is eligible when reqk_wr_en_i=1 and reqk_wr_ack_o=0. This masks the cycle in which the requester sees its ack and is still holding its request.
- Space check: a grant is allowed in cycle N only if q_full_i=0, and additionally q_almost_full_i=0 when q_wr_en_o=1 in cycle N, because the in-flight write consumes the last slot.
- Selection:
  - One eligible port: that port is granted.
  - Both eligible: the port not equal to last_grant is granted.
  - last_grant updates on every grant.
- Grant in cycle N registers, for cycle N+1:
  - q_wr_en_o=1
  - q_wr_data_o = granted port's data
  - reqk_wr_ack_o=1 for the granted port only
- With no grant in cycle N, q_wr_en_o and both acks are 0 in N+1. q_wr_data_o holds its last value.
- busy_o (combinational) = q_wr_en_o | eligible0 | eligible1.
- Requester contract: deassert wr_en, or present a new entry, in the cycle after ack. Re-asserting with new data in that cycle is legal; the entry becomes eligible one cycle later.

## Timing
- Request-to-write latency: 1 cycle (request seen in N, write and ack in N+1).
- Throughput: 1 entry/cycle when ports alternate; a single port is limited to 1 entry every 2 cycles.
- Full: no grant while q_full_i=1. Requests wait indefinitely with no ack and no loss.
- Almost full plus in-flight write: grant withheld one cycle, then re-evaluated against q_full_i.
- Simultaneous requests from idle after reset: port 0 in N+1, port 1 in N+2.
- Reset mid-operation: a pending ack or write in the reset cycle is suppressed on the next edge. The held request re-arbitrates after reset releases. No partial write is ever issued.
- q_wr_en_o is never asserted in a cycle following one where q_full_i=1 at the grant decision.

## Configuration
- DMA_RD_ARB_STATS_EN defined:
  - grant_cnt0_o and grant_cnt1_o increment on each grant to their port and wrap at 2^32.
  - stall_cnt_o increments, saturating at 16'hFFFF, in every cycle where at least one port is eligible but no grant occurs.
  - All counters clear on srst or !en.
- Not defined: the three counter outputs are tied to 0 and no counter registers are synthesized. Arbitration behaviour is identical in both builds.

## Test plan
- Single port 0 entry 64'h1111, queue empty -> q_wr_en_o=1 with data 64'h1111 and req0_wr_ack_o=1 one cycle later; req1_wr_ack_o stays 0.
- Both ports request from reset (64'hA, 64'hB) -> writes 64'hA then 64'hB on consecutive cycles; no entry dropped or duplicated.
- Both ports streaming 8 entries each -> strictly alternating writes (0,1,0,1,…), 16 writes in 16 cycles, grant_cnt0_o=grant_cnt1_o=8 with STATS_EN.
- q_full_i=1 held 5 cycles with port 1 requesting -> no write and no ack for 5 cycles, stall_cnt_o=5; write occurs 1 cycle after q_full_i drops.
- q_almost_full_i=1 with write in flight and new port 0 request -> grant delayed 1 cycle; no write issued while q_full_i=1.
- srst pulsed the cycle after a grant decision -> q_wr_en_o and ack stay 0; the held request is written exactly once after reset releases.

Source files
------------

// File: rtl/dma_rd_q_wr_arb.sv
// Round-robin arbiter merging two held-until-ack write requesters into the DMA read queue write port.
// Optional grant/stall statistics counters are built only when DMA_RD_ARB_STATS_EN is defined.
module dma_rd_q_wr_arb #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              en,
    input  logic              req0_wr_en_i,
    input  logic [DATA_W-1:0] req0_wr_data_i,
    output logic              req0_wr_ack_o,
    input  logic              req1_wr_en_i,
    input  logic [DATA_W-1:0] req1_wr_data_i,
    output logic              req1_wr_ack_o,
    input  logic              q_full_i,
    input  logic              q_almost_full_i,
    output logic              q_wr_en_o,
    output logic [DATA_W-1:0] q_wr_data_o,
    output logic              busy_o,
    output logic [31:0]       grant_cnt0_o,
    output logic [31:0]       grant_cnt1_o,
    output logic [15:0]       stall_cnt_o
);

    logic rst;
    logic elig0;
    logic elig1;
    logic space_ok;
    logic grant0;
    logic grant1;
    logic last_grant;

    assign rst = srst | ~en;

    // A requester still holds its entry during the ack cycle, so the ack masks it.
    assign elig0 = req0_wr_en_i & ~req0_wr_ack_o;
    assign elig1 = req1_wr_en_i & ~req1_wr_ack_o;

    // The write already in flight takes the last free slot when almost full.
    assign space_ok = ~q_full_i & ~(q_almost_full_i & q_wr_en_o);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (space_ok) begin
            if (elig0 && elig1) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_wr_en_o     <= 1'b0;
            q_wr_data_o   <= '0;
            req0_wr_ack_o <= 1'b0;
            req1_wr_ack_o <= 1'b0;
            last_grant    <= 1'b1;
        end else begin
            q_wr_en_o     <= grant0 | grant1;
            req0_wr_ack_o <= grant0;
            req1_wr_ack_o <= grant1;
            if (grant0) begin
                q_wr_data_o <= req0_wr_data_i;
                last_grant  <= 1'b0;
            end else if (grant1) begin
                q_wr_data_o <= req1_wr_data_i;
                last_grant  <= 1'b1;
            end
        end
    end

    assign busy_o = ~rst & (q_wr_en_o | elig0 | elig1);

`ifdef DMA_RD_ARB_STATS_EN
    logic [31:0] cnt0;
    logic [31:0] cnt1;
    logic [15:0] stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0  <= '0;
            cnt1  <= '0;
            stall <= '0;
        end else begin
            if (grant0) begin
                cnt0 <= cnt0 + 32'd1;
            end
            if (grant1) begin
                cnt1 <= cnt1 + 32'd1;
            end
            if ((elig0 || elig1) && !(grant0 || grant1) && (stall != 16'hFFFF)) begin
                stall <= stall + 16'd1;
            end
        end
    end

    assign grant_cnt0_o = cnt0;
    assign grant_cnt1_o = cnt1;
    assign stall_cnt_o  = stall;
`else
    assign grant_cnt0_o = '0;
    assign grant_cnt1_o = '0;
    assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_dma_rd_q_wr_arb.sv
// Scoreboard bench for dma_rd_q_wr_arb: requester models feed both ports, a monitor checks every queue write.
// Counter expectations follow whether DMA_RD_ARB_STATS_EN is defined for the build.
module tb_dma_rd_q_wr_arb;

    localparam int DATA_W = 64;
`ifdef DMA_RD_ARB_STATS_EN
    localparam logic [63:0] STATS = 64'd1;
`else
    localparam logic [63:0] STATS = 64'd0;
`endif

    typedef struct {
        bit          port;
        logic [63:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              srst;
    logic              en;
    logic              req0_wr_en;
    logic [DATA_W-1:0] req0_wr_data;
    logic              req0_wr_ack;
    logic              req1_wr_en;
    logic [DATA_W-1:0] req1_wr_data;
    logic              req1_wr_ack;
    logic              q_full;
    logic              q_almost_full;
    logic              q_wr_en;
    logic [DATA_W-1:0] q_wr_data;
    logic              busy;
    logic [31:0]       grant_cnt0;
    logic [31:0]       grant_cnt1;
    logic [15:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [63:0] pend0[$];
    logic [63:0] pend1[$];
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    dma_rd_q_wr_arb #(.DATA_W(DATA_W)) dut (
        .clk            (clk),
        .srst           (srst),
        .en             (en),
        .req0_wr_en_i   (req0_wr_en),
        .req0_wr_data_i (req0_wr_data),
        .req0_wr_ack_o  (req0_wr_ack),
        .req1_wr_en_i   (req1_wr_en),
        .req1_wr_data_i (req1_wr_data),
        .req1_wr_ack_o  (req1_wr_ack),
        .q_full_i       (q_full),
        .q_almost_full_i(q_almost_full),
        .q_wr_en_o      (q_wr_en),
        .q_wr_data_o    (q_wr_data),
        .busy_o         (busy),
        .grant_cnt0_o   (grant_cnt0),
        .grant_cnt1_o   (grant_cnt1),
        .stall_cnt_o    (stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Queue an entry on a requester and record the write it should produce, in hand-computed order.
    task automatic applyStimulus(input bit port, input logic [63:0] data);
        if (port) pend1.push_back(data);
        else      pend0.push_back(data);
        exp_q.push_back('{port: port, data: data});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset(input bit use_en);
        if (use_en) en = 1'b0;
        else        srst = 1'b1;
        tick();
        tick();
        checkOutput("rst_wr_en", q_wr_en, 0);
        checkOutput("rst_wr_data", q_wr_data, 0);
        checkOutput("rst_ack0", req0_wr_ack, 0);
        checkOutput("rst_ack1", req1_wr_ack, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cnt0", grant_cnt0, 0);
        checkOutput("rst_cnt1", grant_cnt1, 0);
        checkOutput("rst_stall", stall_cnt, 0);
        srst = 1'b0;
        en   = 1'b1;
    endtask

    // Requester models: hold the entry until the ack is seen, then deassert or present the next one.
    initial begin
        req0_wr_en   = 1'b0;
        req0_wr_data = '0;
        forever begin
            @(negedge clk);
            if (req0_wr_en && req0_wr_ack) req0_wr_en = 1'b0;
            if (!req0_wr_en && pend0.size() > 0) begin
                req0_wr_data = pend0.pop_front();
                req0_wr_en   = 1'b1;
            end
        end
    end

    initial begin
        req1_wr_en   = 1'b0;
        req1_wr_data = '0;
        forever begin
            @(negedge clk);
            if (req1_wr_en && req1_wr_ack) req1_wr_en = 1'b0;
            if (!req1_wr_en && pend1.size() > 0) begin
                req1_wr_data = pend1.pop_front();
                req1_wr_en   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (q_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_spurious_write", q_wr_data, 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_data", q_wr_data, e.data);
                checkOutput("sb_ack0", {63'd0, req0_wr_ack}, e.port ? 64'd0 : 64'd1);
                checkOutput("sb_ack1", {63'd0, req1_wr_ack}, e.port ? 64'd1 : 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        srst          = 1'b1;
        en            = 1'b1;
        q_full        = 1'b0;
        q_almost_full = 1'b0;
        tick();
        doReset(1'b0);

        // Single port 0 entry: write and ack one cycle after the request is seen.
        applyStimulus(1'b0, 64'h1111);
        tick();
        checkOutput("t1_wr_en", q_wr_en, 1);
        checkOutput("t1_ack0", req0_wr_ack, 1);
        checkOutput("t1_ack1", req1_wr_ack, 0);
        checkOutput("t1_busy", busy, 1);
        tick();
        checkOutput("t1_idle_wr_en", q_wr_en, 0);
        checkOutput("t1_idle_ack0", req0_wr_ack, 0);

        // Simultaneous requests after reset (via en): port 0 first, then port 1.
        doReset(1'b1);
        applyStimulus(1'b0, 64'hA);
        applyStimulus(1'b1, 64'hB);
        tick();
        checkOutput("t2_first_ack0", req0_wr_ack, 1);
        tick();
        checkOutput("t2_second_wr_en", q_wr_en, 1);
        checkOutput("t2_second_ack1", req1_wr_ack, 1);
        tick();
        checkOutput("t2_done_wr_en", q_wr_en, 0);

        // Both ports streaming 8 entries: strictly alternating, one write per cycle.
        doReset(1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 64'h100 + 64'(i));
            applyStimulus(1'b1, 64'h200 + 64'(i));
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (q_wr_en !== 1'b1 && n < 5);
        checkOutput("t3_first_latency", 64'(n), 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            checkOutput("t3_contiguous", q_wr_en, 1);
        end
        tick();
        checkOutput("t3_end_wr_en", q_wr_en, 0);
        checkOutput("t3_cnt0", grant_cnt0, 8 * STATS);
        checkOutput("t3_cnt1", grant_cnt1, 8 * STATS);
        checkOutput("t3_stall", stall_cnt, 0);

        // Queue full for 5 cycles with port 1 waiting.
        doReset(1'b0);
        q_full = 1'b1;
        applyStimulus(1'b1, 64'h2222);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t4_full_wr_en", q_wr_en, 0);
            checkOutput("t4_full_ack1", req1_wr_ack, 0);
        end
        checkOutput("t4_full_busy", busy, 1);
        q_full = 1'b0;
        tick();
        checkOutput("t4_release_wr_en", q_wr_en, 1);
        checkOutput("t4_release_ack1", req1_wr_ack, 1);
        checkOutput("t4_stall", stall_cnt, 5 * STATS);

        // Almost full with a write in flight: the next grant slips one cycle.
        doReset(1'b0);
        q_almost_full = 1'b1;
        applyStimulus(1'b1, 64'h33);
        tick();
        checkOutput("t5_first_wr_en", q_wr_en, 1);
        applyStimulus(1'b0, 64'h44);
        tick();
        checkOutput("t5_withheld_wr_en", q_wr_en, 0);
        checkOutput("t5_withheld_ack0", req0_wr_ack, 0);
        tick();
        checkOutput("t5_delayed_wr_en", q_wr_en, 1);
        checkOutput("t5_delayed_ack0", req0_wr_ack, 1);
        q_full = 1'b1;
        applyStimulus(1'b0, 64'h55);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t5_full_wr_en", q_wr_en, 0);
        end
        q_full = 1'b0;
        tick();
        checkOutput("t5_after_full_wr_en", q_wr_en, 1);
        q_almost_full = 1'b0;

        // Reset in the grant cycle suppresses the write; the held request goes out exactly once.
        doReset(1'b0);
        applyStimulus(1'b0, 64'h77);
        srst = 1'b1;
        tick();
        checkOutput("t6_rst_wr_en", q_wr_en, 0);
        checkOutput("t6_rst_ack0", req0_wr_ack, 0);
        checkOutput("t6_rst_busy", busy, 0);
        srst = 1'b0;
        tick();
        checkOutput("t6_wr_en", q_wr_en, 1);
        checkOutput("t6_ack0", req0_wr_ack, 1);
        tick();
        checkOutput("t6_once_wr_en", q_wr_en, 0);
        tick();
        checkOutput("t6_idle_wr_en", q_wr_en, 0);

        checkOutput("sb_drained", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
